// File: rtl/bit_mem_pkg.sv
// Shared constants and state encoding for the 32x1 bit memory loader.
package bit_mem_pkg;

    localparam int unsigned BIT_MEM_ADDR_W = 5;
    localparam int unsigned BIT_MEM_DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } bit_mem_load_state_t;

endpackage

// File: rtl/bit_mem_loader.sv
// Serializes one accepted word into DEPTH single-bit memory writes, then pulses done.
// Optional readback pass enabled by BIT_MEM_LOADER_VERIFY_EN.
module bit_mem_loader
    import bit_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = BIT_MEM_ADDR_W,
    parameter int unsigned DEPTH     = BIT_MEM_DEPTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEPTH-1:0]  in_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_din,
`ifdef BIT_MEM_LOADER_VERIFY_EN
    input  logic              mem_dout,
    output logic              verify_err,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    bit_mem_load_state_t state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]    word_q, word_d;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                mem_din_d;
    logic                done_d;
`ifdef BIT_MEM_LOADER_VERIFY_EN
    logic                err_q, err_d;
    logic                verify_err_d;
    logic                mismatch;
`endif

    // Bit of the word destined for address a, honouring bit ordering.
    function automatic logic word_bit(input logic [DEPTH-1:0] w, input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] idx;
        idx = LSB_FIRST ? a : (LAST - a);
        return w[idx];
    endfunction

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

`ifdef BIT_MEM_LOADER_VERIFY_EN
    assign mismatch = (mem_dout != word_bit(word_q, count_q));
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_d     = word_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr;
        mem_din_d  = 1'b0;
        done_d     = 1'b0;
`ifdef BIT_MEM_LOADER_VERIFY_EN
        err_d        = err_q;
        verify_err_d = verify_err;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = WRITE;
                    word_d     = in_word;
                    count_d    = '0;
                    mem_we_d   = 1'b1;
                    mem_addr_d = '0;
                    mem_din_d  = word_bit(in_word, ADDR_W'(0));
`ifdef BIT_MEM_LOADER_VERIFY_EN
                    err_d        = 1'b0;
                    verify_err_d = 1'b0;
`endif
                end
            end
            // count_q always equals the address currently presented
            WRITE: begin
                if (count_q == LAST) begin
                    count_d = '0;
`ifdef BIT_MEM_LOADER_VERIFY_EN
                    state_d    = VERIFY;
                    mem_addr_d = '0;
`else
                    state_d    = DONE;
                    done_d     = 1'b1;
`endif
                end else begin
                    count_d    = count_q + ADDR_W'(1);
                    mem_we_d   = 1'b1;
                    mem_addr_d = count_d;
                    mem_din_d  = word_bit(word_q, count_d);
                end
            end
            VERIFY: begin
`ifdef BIT_MEM_LOADER_VERIFY_EN
                err_d = err_q | mismatch;
                if (count_q == LAST) begin
                    count_d      = '0;
                    state_d      = DONE;
                    done_d       = 1'b1;
                    verify_err_d = err_q | mismatch;
                end else begin
                    count_d    = count_q + ADDR_W'(1);
                    mem_addr_d = count_d;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            word_q   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 1'b0;
            done     <= 1'b0;
`ifdef BIT_MEM_LOADER_VERIFY_EN
            err_q      <= 1'b0;
            verify_err <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            word_q   <= word_d;
            mem_we   <= mem_we_d;
            mem_addr <= mem_addr_d;
            mem_din  <= mem_din_d;
            done     <= done_d;
`ifdef BIT_MEM_LOADER_VERIFY_EN
            err_q      <= err_d;
            verify_err <= verify_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_mem_loader.sv
// Self-checking bench: two loaders (LSB-first and MSB-first) driven by the same words.
module tb_bit_mem_loader;
    import bit_mem_pkg::*;

    localparam int unsigned AW = BIT_MEM_ADDR_W;
    localparam int unsigned DP = BIT_MEM_DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DP-1:0] in_word;

    logic          ready_l, we_l, din_l, busy_l, done_l;
    logic [AW-1:0] addr_l;
    logic          ready_m, we_m, din_m, busy_m, done_m;
    logic [AW-1:0] addr_m;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BIT_MEM_LOADER_VERIFY_EN
    logic dout_l, dout_m, verr_l, verr_m;
    bit   stub = 1'b0;
    logic mem_l [DP];
    logic mem_m [DP];

    always @(posedge clk) begin
        if (we_l) mem_l[addr_l] <= din_l;
        if (we_m) mem_m[addr_m] <= din_m;
    end
    assign dout_l = stub ? 1'b1 : mem_l[addr_l];
    assign dout_m = stub ? 1'b1 : mem_m[addr_m];
`endif

    always #5 clk = ~clk;

    bit_mem_loader #(.ADDR_W(AW), .DEPTH(DP), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_l), .in_word(in_word),
        .mem_we(we_l), .mem_addr(addr_l), .mem_din(din_l),
`ifdef BIT_MEM_LOADER_VERIFY_EN
        .mem_dout(dout_l), .verify_err(verr_l),
`endif
        .busy(busy_l), .done(done_l)
    );

    bit_mem_loader #(.ADDR_W(AW), .DEPTH(DP), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_m), .in_word(in_word),
        .mem_we(we_m), .mem_addr(addr_m), .mem_din(din_m),
`ifdef BIT_MEM_LOADER_VERIFY_EN
        .mem_dout(dout_m), .verify_err(verr_m),
`endif
        .busy(busy_m), .done(done_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: address k stores bit k (lsb first) or bit DEPTH-1-k (msb first)
    function automatic logic exp_bit(input logic [31:0] w, input int k, input bit lsb);
        logic [31:0] s;
        int pos;
        pos = lsb ? k : (int'(DP) - 1 - k);
        s = w >> pos;
        return s[0];
    endfunction

    task automatic chk_both(input string tag, input logic l, input logic m, input logic exp);
        chk({tag, "_lsb"}, 32'(l), 32'(exp));
        chk({tag, "_msb"}, 32'(m), 32'(exp));
    endtask

    // Entered at a negedge of an idle cycle; returns at a negedge of an idle cycle.
    task automatic run_word(input logic [31:0] w, input bit hold, input logic [31:0] nxt,
                            input int abort_k);
        chk_both("ready_pre", ready_l, ready_m, 1'b1);
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        in_valid = hold;
        in_word  = hold ? nxt : $urandom;
        for (int k = 0; k < int'(DP); k++) begin
            chk_both("wr_we", we_l, we_m, 1'b1);
            chk("wr_addr_lsb", 32'(addr_l), 32'(k));
            chk("wr_addr_msb", 32'(addr_m), 32'(k));
            chk("wr_din_lsb", 32'(din_l), 32'(exp_bit(w, k, 1'b1)));
            chk("wr_din_msb", 32'(din_m), 32'(exp_bit(w, k, 1'b0)));
            chk_both("wr_busy", busy_l, busy_m, 1'b1);
            chk_both("wr_ready", ready_l, ready_m, 1'b0);
            chk_both("wr_done", done_l, done_m, 1'b0);
`ifdef BIT_MEM_LOADER_VERIFY_EN
            chk_both("wr_verr", verr_l, verr_m, 1'b0);
`endif
            if (k == abort_k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_both("abort_we", we_l, we_m, 1'b0);
                chk_both("abort_busy", busy_l, busy_m, 1'b0);
                chk_both("abort_ready", ready_l, ready_m, 1'b1);
                for (int c = 0; c < int'(DP) + 4; c++) begin
                    chk_both("abort_nodone", done_l, done_m, 1'b0);
                    @(negedge clk);
                end
                return;
            end
            if (!hold) in_word = $urandom;
            @(negedge clk);
        end
`ifdef BIT_MEM_LOADER_VERIFY_EN
        for (int k = 0; k < int'(DP); k++) begin
            chk_both("vf_we", we_l, we_m, 1'b0);
            chk("vf_addr_lsb", 32'(addr_l), 32'(k));
            chk("vf_addr_msb", 32'(addr_m), 32'(k));
            chk_both("vf_din", din_l, din_m, 1'b0);
            chk_both("vf_done", done_l, done_m, 1'b0);
            chk_both("vf_busy", busy_l, busy_m, 1'b1);
            @(negedge clk);
        end
`endif
        chk_both("dn_done", done_l, done_m, 1'b1);
        chk_both("dn_we", we_l, we_m, 1'b0);
        chk_both("dn_ready", ready_l, ready_m, 1'b0);
        chk_both("dn_busy", busy_l, busy_m, 1'b1);
`ifdef BIT_MEM_LOADER_VERIFY_EN
        chk_both("dn_verr", verr_l, verr_m, stub && (w != 32'hFFFF_FFFF));
`endif
        @(negedge clk);
        chk_both("id_ready", ready_l, ready_m, 1'b1);
        chk_both("id_busy", busy_l, busy_m, 1'b0);
        chk_both("id_done", done_l, done_m, 1'b0);
        chk_both("id_we", we_l, we_m, 1'b0);
        chk("id_addr_lsb", 32'(addr_l), 32'(DP - 1));
        chk("id_addr_msb", 32'(addr_m), 32'(DP - 1));
`ifdef BIT_MEM_LOADER_VERIFY_EN
        chk_both("id_verr", verr_l, verr_m, stub && (w != 32'hFFFF_FFFF));
`endif
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = '0;
        repeat (2) @(negedge clk);
        chk_both("rst_we", we_l, we_m, 1'b0);
        chk("rst_addr_lsb", 32'(addr_l), 32'd0);
        chk("rst_addr_msb", 32'(addr_m), 32'd0);
        chk_both("rst_din", din_l, din_m, 1'b0);
        chk_both("rst_done", done_l, done_m, 1'b0);
        chk_both("rst_busy", busy_l, busy_m, 1'b0);
`ifdef BIT_MEM_LOADER_VERIFY_EN
        chk_both("rst_verr", verr_l, verr_m, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_word(32'hA5A5_0F0F, 1'b0, 32'h0, -1);
        run_word(32'h8000_0001, 1'b0, 32'h0, -1);
        run_word(32'hFFFF_FFFF, 1'b1, 32'h0000_0000, -1);
        run_word(32'h0000_0000, 1'b0, 32'h0, -1);
        run_word(32'h1234_5678, 1'b0, 32'h0, -1);
        for (int i = 0; i < 4; i++) begin
            run_word($urandom, 1'b0, 32'h0, -1);
        end
        run_word($urandom, 1'b0, 32'h0, 9);
        run_word($urandom, 1'b0, 32'h0, -1);
`ifdef BIT_MEM_LOADER_VERIFY_EN
        stub = 1'b1;
        run_word(32'h0000_0000, 1'b0, 32'h0, -1);
        run_word(32'hFFFF_FFFF, 1'b0, 32'h0, -1);
        stub = 1'b0;
        run_word($urandom, 1'b0, 32'h0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
